// File: rtl/fifo_rr_arbiter_if.sv
// Source-side and destination-side handshake bundle for fifo_rr_arbiter.
// The master modport is the arbiter view; slave is the FIFO/consumer view.
interface fifo_rr_arbiter_if #(
  parameter int bits  = 8,
  parameter int ports = 4
);
  localparam int IW = $clog2(ports);

  logic [ports-1:0]      src_not_empty;
  logic [ports*bits-1:0] src_data;
  logic [ports-1:0]      src_last;
  logic [ports-1:0]      src_shift_out;
  logic                  dst_ready;
  logic                  dst_valid;
  logic [bits-1:0]       dst_data;
  logic [IW-1:0]         dst_src;
  logic                  dst_last;
  logic [ports-1:0]      grant;
  logic                  busy;

  modport master (
    input  src_not_empty, src_data, src_last, dst_ready,
    output src_shift_out, dst_valid, dst_data, dst_src, dst_last, grant, busy
  );

  modport slave (
    output src_not_empty, src_data, src_last, dst_ready,
    input  src_shift_out, dst_valid, dst_data, dst_src, dst_last, grant, busy
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin merge of several look-ahead FIFOs into one registered stream.
// A grant is held for one burst: until the source's last tag or max_burst words.
module fifo_rr_arbiter #(
  parameter int bits      = 8,
  parameter int ports     = 4,
  parameter int max_burst = 4
) (
  input logic               clk,
  input logic               reset,
  fifo_rr_arbiter_if.master bus
);
  localparam int          IW = $clog2(ports);
  localparam int          BW = $clog2(max_burst + 1);
  localparam int unsigned NP = ports;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ports-1:0] grant_q, grant_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             dst_valid_q, dst_valid_d;
  logic [bits-1:0]  dst_data_q, dst_data_d;
  logic [IW-1:0]    dst_src_q, dst_src_d;
  logic             dst_last_q, dst_last_d;

  logic             load, pop, last_word, found;
  logic [IW-1:0]    winner, cand;
  logic [bits-1:0]  owner_data;
  logic [ports-1:0] shift;

  // First requester after rr_ptr, wrapping modulo ports.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= NP; i++) begin
      cand = IW'((32'(rr_ptr_q) + i) % NP);
      if (!found && bus.src_not_empty[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // rr_ptr_q doubles as the owner index while in LOCK.
  assign load       = !dst_valid_q || bus.dst_ready;
  assign pop        = (state_q == LOCK) && load && bus.src_not_empty[rr_ptr_q] && !reset;
  assign owner_data = bus.src_data[int'(rr_ptr_q) * bits +: bits];
  assign last_word  = bus.src_last[rr_ptr_q] || (beat_q == BW'(max_burst - 1));

  always_comb begin
    shift           = '0;
    shift[rr_ptr_q] = pop;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_d      = beat_q;
    dst_valid_d = dst_valid_q;
    dst_data_d  = dst_data_q;
    dst_src_d   = dst_src_q;
    dst_last_d  = dst_last_q;
    if (dst_valid_q && bus.dst_ready) dst_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d         = LOCK;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          rr_ptr_d        = winner;
          beat_d          = '0;
        end
      end
      default: begin
        if (pop) begin
          dst_valid_d = 1'b1;
          dst_data_d  = owner_data;
          dst_src_d   = rr_ptr_q;
          dst_last_d  = last_word;
          beat_d      = beat_q + 1'b1;
          if (last_word) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= IW'(ports - 1);
      beat_q      <= '0;
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
      dst_src_q   <= '0;
      dst_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_q      <= beat_d;
      dst_valid_q <= dst_valid_d;
      dst_data_q  <= dst_data_d;
      dst_src_q   <= dst_src_d;
      dst_last_q  <= dst_last_d;
    end
  end

  assign bus.src_shift_out = shift;
  assign bus.dst_valid     = dst_valid_q;
  assign bus.dst_data      = dst_data_q;
  assign bus.dst_src       = dst_src_q;
  assign bus.dst_last      = dst_last_q;
  assign bus.grant         = grant_q;
  assign bus.busy          = (state_q == LOCK);
endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Merges the output sides of up to `ports` zero-latency 3-word FIFOs into one registered downstream stream.
- Round-robin grant, locked per burst: a grant holds until the source marks its last word, or `max_burst` words have been popped.
- Drives each FIFO's shift_out directly, so FIFO look-ahead data and not_empty flags are consumed without extra buffering.
- Sits between per-channel FIFOs and a shared consumer (serializer or bus master).

Parameters:
- bits, 8, data word width (matches FIFO `bits`)
- ports, 4, number of source FIFOs; legal range 2..16
- max_burst, 4, maximum words per grant before forced release; legal range 1..255

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- src_not_empty  input  ports  per-source FIFO not-empty flag
- src_data  input  ports*bits  per-source FIFO data_out; source i occupies bits [i*bits +: bits]
- src_last  input  ports  per-source end-of-burst tag, valid alongside src_data
- src_shift_out  output  ports  per-source pop strobe, at most one bit high
- dst_ready  input  1  consumer accepts dst word this cycle
- dst_valid  output  1  output register holds a word
- dst_data  output  bits  output word
- dst_src  output  $clog2(ports)  index of the source that supplied dst_data
- dst_last  output  1  final word of its grant
- grant  output  ports  one-hot current owner; all-zero when idle
- busy  output  1  high while a grant is held

Behaviour:
- Reset values:
  - state=IDLE, grant=0, busy=0, beat_cnt=0, rr_ptr=ports-1.
  - dst_valid=0, dst_data=0, dst_src=0, dst_last=0.
  - src_shift_out=0 in the reset cycle.
- A reset asserted mid-burst abandons the burst. No pop occurs in the reset cycle; words already popped into the output register are discarded.
- Output register is free when `load = !dst_valid || dst_ready`.
- States:
  - IDLE:
    - If any src_not_empty bit is set, pick the first set index searching rr_ptr+1, rr_ptr+2, … modulo ports.
    - Register grant=onehot(winner), set rr_ptr=winner, clear beat_cnt, go to LOCK.
    - No pop occurs in IDLE.
  - LOCK (owner o):
    - pop = load && src_not_empty[o]; src_shift_out[o] = pop, combinational from registered state and current inputs.
    - On pop, capture into the output register: dst_data<=src_data[o], dst_src<=o, dst_valid<=1, dst_last<=src_last[o] || (beat_cnt==max_burst-1); then increment beat_cnt.
    - If the popped word has dst_last set, go to IDLE and clear grant.
    - If the owner is empty, stay in LOCK and wait; the grant is never released on an empty FIFO.
- When dst_valid && dst_ready and there is no pop this cycle, dst_valid<=0.
- Output register holds its contents while dst_valid && !dst_ready.
- Latency: src_not_empty rises in cycle n in IDLE → grant and first pop in n+1 → dst_valid in n+2.
- Throughput: back-to-back words within a burst when dst_ready=1. One IDLE bubble cycle between grants.
- Fairness: rr_ptr updates only on entering LOCK. A source just served is last in priority on the next arbitration.
- Overflow and underflow safety:
  - src_shift_out never asserts for a source whose src_not_empty=0.
  - src_shift_out never asserts for more than one source.
  - Nothing is popped unless the output register is free.
- Only the owner's src_data and src_last are sampled. Other sources' inputs are don't-care.
- beat_cnt width is $clog2(max_burst+1). For max_burst=1, every popped word is dst_last.
- busy = (state==LOCK); grant is all-zero whenever busy=0.

Test Plan:
- Reset then idle: all src_not_empty=0 → grant=0, busy=0, dst_valid=0, src_shift_out=0 indefinitely.
- Single source: source 2 holds 3 words A,B,C, last on C, dst_ready=1. Expected:
  - grant=4'b0100 one cycle after request.
  - dst stream A,B,C on consecutive cycles with dst_src=2 and dst_last only on C.
  - Then return to IDLE.
- Round-robin: all 4 sources hold single-word bursts (last=1) from reset → service order 0,1,2,3,0, each separated by one IDLE cycle.
- Burst cap: source 1 streams 6 words with no last, max_burst=4, source 3 also requesting. Expected:
  - 4 words from source 1, dst_last on the 4th.
  - Then source 3 is granted.
  - Then source 1 resumes with its words 5 and 6.
- Back-pressure: dst_ready=0 for 5 cycles mid-burst → dst_data and dst_valid are held, src_shift_out=0, no word lost or duplicated when dst_ready returns to 1.
- Reset mid-burst: assert reset after 2 of 4 words → next cycle busy=0, dst_valid=0, rr_ptr=3, and the next arbitration starts at source 0.
